// File: rtl/mem_map_pkg.sv
// Address map and shared constants for mem_bus_decoder.
// Region tables are packed arrays, indexed by region number. Index 0 is the LSB slice.
package mem_map_pkg;

  localparam int MAP_NUM_REGIONS = 4;
  localparam int MAP_NUM_TARGETS = 3;
  localparam int MAP_ADDR_W      = 32;
  localparam int MAP_PADDR_W     = 13;
  localparam int MAP_WAIT_W      = 4;
  localparam int TGT_W           = 2;

  localparam logic [TGT_W-1:0] TGT_DATA = 2'd0;
  localparam logic [TGT_W-1:0] TGT_VGA  = 2'd1;
  localparam logic [TGT_W-1:0] TGT_IO   = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;

  // Region order: 3 I/O, 2 VGA, 1 stack, 0 data.
  localparam logic [MAP_NUM_REGIONS-1:0][MAP_ADDR_W-1:0] REGION_BASE =
    {32'hFFFF_0000, 32'h0000_B800, 32'h7FFF_EFFC, 32'h1001_0000};
  localparam logic [MAP_NUM_REGIONS-1:0][MAP_ADDR_W-1:0] REGION_LIMIT =
    {32'hFFFF_000F, 32'h0000_CABF, 32'h7FFF_FFFB, 32'h1001_0FFF};
  localparam logic [MAP_NUM_REGIONS-1:0][MAP_ADDR_W-1:0] REGION_SUB =
    {32'hFFFF_0000, 32'h0000_B800, 32'h7FFF_DFFC, 32'h1001_0000};
  localparam logic [MAP_NUM_REGIONS-1:0][TGT_W-1:0] REGION_TGT =
    {TGT_IO, TGT_VGA, TGT_DATA, TGT_DATA};
  localparam logic [MAP_NUM_REGIONS-1:0][MAP_WAIT_W-1:0] REGION_WAIT =
    {4'd2, 4'd1, 4'd0, 4'd0};

  // 0=byte 1=half 2=word; size 3 is undefined and treated as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = |a;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// Single region window compare: base <= addr <= limit, unsigned, limit inclusive.
module mem_region_match #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  output logic              hit
);

  assign hit = (addr >= base) && (addr <= limit);

endmodule

// File: rtl/mem_bus_decoder.sv
// Registered memory bus decoder: region match, one-hot target enable, wait states, fault capture.
// Optional MISALIGN_CHECK_EN: misaligned half/word (or size 3) accesses take the fault path.
module mem_bus_decoder
  import mem_map_pkg::*;
#(
  parameter int NUM_REGIONS = MAP_NUM_REGIONS,
  parameter int NUM_TARGETS = MAP_NUM_TARGETS,
  parameter int ADDR_W      = MAP_ADDR_W,
  parameter int PADDR_W     = MAP_PADDR_W,
  parameter int WAIT_W      = MAP_WAIT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_w,
  input  logic                   mem_r,
  input  logic [1:0]             mem_size,
  input  logic [ADDR_W-1:0]      vaddr,
  input  logic                   fault_clr,
  output logic                   busy,
  output logic [NUM_TARGETS-1:0] men,
  output logic [1:0]             msel,
  output logic [PADDR_W-1:0]     pad,
  output logic                   done,
  output logic                   iad,
  output logic                   fault_valid,
  output logic [ADDR_W-1:0]      fault_addr
);

  localparam int RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [1:0]             state;
  logic [WAIT_W-1:0]      cnt;
  logic [NUM_REGIONS-1:0] hit;
  logic                   any_hit;
  logic [RIDX_W-1:0]      sel;
  logic                   req;
  logic                   accept;
  logic                   misalign;
  logic                   bad;
  logic [PADDR_W-1:0]     pad_nxt;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    mem_region_match #(.ADDR_W(ADDR_W)) u_match (
      .addr  (vaddr),
      .base  (REGION_BASE[g]),
      .limit (REGION_LIMIT[g]),
      .hit   (hit[g])
    );
  end

  // Scan high to low so the lowest matching index is the one left in sel.
  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sel     = RIDX_W'(i);
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign misalign = misaligned(mem_size, vaddr[1:0]);
`else
  logic unused_size;
  assign unused_size = ^mem_size;
  assign misalign    = 1'b0;
`endif

  assign req     = mem_w | mem_r;
  assign accept  = (state == ST_IDLE) && req;
  assign bad     = (mem_w & mem_r) | ~any_hit | misalign;
  assign pad_nxt = PADDR_W'(vaddr - REGION_SUB[sel]);

  assign busy = (state != ST_IDLE);
  assign done = ((state == ST_ACCESS) && (cnt == '0)) || (state == ST_ERR);
  assign iad  = (state == ST_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      men   <= '0;
      msel  <= '0;
      pad   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bad) begin
              state <= ST_ERR;
              men   <= '0;
              msel  <= '0;
              pad   <= '0;
            end else begin
              state <= ST_ACCESS;
              men   <= {{(NUM_TARGETS-1){1'b0}}, 1'b1} << REGION_TGT[sel];
              msel  <= REGION_TGT[sel];
              pad   <= pad_nxt;
              cnt   <= REGION_WAIT[sel];
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            men   <= '0;
            msel  <= '0;
            pad   <= '0;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        ST_ERR: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          men   <= '0;
          msel  <= '0;
          pad   <= '0;
        end
      endcase
    end
  end

  // Only the first fault since the last clear is recorded; a clear beats a same-cycle capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
    end else if (fault_clr) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
    end else if (accept && bad && !fault_valid) begin
      fault_valid <= 1'b1;
      fault_addr  <= vaddr;
    end
  end

endmodule
